// File: rtl/rcpu_mc.sv
// rcpu_mc: multi-cycle MIPS-subset core (FETCH/DECODE/EXEC/WB, HALTED terminal).
// Latency: 4 cycles per instruction with a zero-wait fetch, +1 cycle per fetch wait cycle.
// Backpressure: imem_req held high with a stable imem_addr until imem_ack; ack ignored elsewhere.
module rcpu_mc #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 8,
  parameter int NREG_LOG2 = 5
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   imem_addr,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [31:0]       imem_data,
  output logic [DATA_W-1:0] ALU_F,
  output logic              ZF,
  output logic              OF,
  output logic              halt
);
  localparam int NREG = 1 << NREG_LOG2;
  localparam int SHW  = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WB     = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLLV = 4'd8;
  localparam logic [3:0] OP_BEQ  = 4'd9;

  logic [2:0]           state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [31:0]          ir_q;
  logic                 req_q;
  logic [DATA_W-1:0]    rf_q [NREG];
  logic [DATA_W-1:0]    a_q, b_q, alu_q;
  logic                 zf_q, of_q;
  logic [3:0]           aluop_q;
  logic                 wr_en_q;
  logic [NREG_LOG2-1:0] dst_q;
  logic [PC_W-1:0]      br_off_q;

  // Instruction fields; register indices keep only the low NREG_LOG2 bits.
  logic [5:0]           opc, fn;
  logic [NREG_LOG2-1:0] rs, rt, rd;
  logic [63:0]          sext64, zext64, off64;
  assign opc    = ir_q[31:26];
  assign fn     = ir_q[5:0];
  assign rs     = ir_q[21 +: NREG_LOG2];
  assign rt     = ir_q[16 +: NREG_LOG2];
  assign rd     = ir_q[11 +: NREG_LOG2];
  assign sext64 = {{48{ir_q[15]}}, ir_q[15:0]};
  assign zext64 = {48'd0, ir_q[15:0]};
  assign off64  = sext64 << 2;

  // Fields not every configuration consumes (shamt, upper extension bits).
  logic unused_ok;
  assign unused_ok = ^{ir_q, sext64, zext64, off64};

  logic [3:0]           dec_op;
  logic                 dec_wr, dec_use_imm;
  logic [NREG_LOG2-1:0] dec_dst;
  logic [DATA_W-1:0]    dec_imm;

  // Decode: ALU operation, destination and second operand source.
  always_comb begin
    dec_op      = OP_NONE;
    dec_wr      = 1'b0;
    dec_dst     = rd;
    dec_use_imm = 1'b0;
    dec_imm     = sext64[DATA_W-1:0];
    case (opc)
      6'b000000: begin
        dec_wr = 1'b1;
        case (fn)
          6'b100000: dec_op = OP_ADD;
          6'b100010: dec_op = OP_SUB;
          6'b100100: dec_op = OP_AND;
          6'b100101: dec_op = OP_OR;
          6'b100110: dec_op = OP_XOR;
          6'b100111: dec_op = OP_NOR;
          6'b101011: dec_op = OP_SLTU;
          6'b000100: dec_op = OP_SLLV;
          default:   dec_wr = 1'b0;
        endcase
      end
      6'b001000: begin dec_op = OP_ADD; dec_wr = 1'b1; dec_dst = rt; dec_use_imm = 1'b1; end
      6'b001100: begin
        dec_op = OP_AND; dec_wr = 1'b1; dec_dst = rt; dec_use_imm = 1'b1;
        dec_imm = zext64[DATA_W-1:0];
      end
      6'b001101: begin
        dec_op = OP_OR; dec_wr = 1'b1; dec_dst = rt; dec_use_imm = 1'b1;
        dec_imm = zext64[DATA_W-1:0];
      end
      6'b000100: dec_op = OP_BEQ;
      default:   dec_op = OP_NONE;
    endcase
  end

  logic [DATA_W-1:0] sum, diff, alu_d;
  logic              of_d, alu_upd;
  assign sum  = a_q + b_q;
  assign diff = a_q - b_q;

  // ALU: undefined operations leave the flag registers untouched.
  always_comb begin
    alu_d   = alu_q;
    of_d    = 1'b0;
    alu_upd = 1'b1;
    case (aluop_q)
      OP_ADD:  begin alu_d = sum;  of_d = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]); end
      OP_SUB:  begin alu_d = diff; of_d = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]); end
      OP_AND:  alu_d = a_q & b_q;
      OP_OR:   alu_d = a_q | b_q;
      OP_XOR:  alu_d = a_q ^ b_q;
      OP_NOR:  alu_d = ~(a_q | b_q);
      OP_SLTU: alu_d = DATA_W'(a_q < b_q);
      OP_SLLV: alu_d = b_q << a_q[SHW-1:0];
      OP_BEQ:  alu_d = diff;
      default: alu_upd = 1'b0;
    endcase
  end

  // Next state; HALT is recognised in DECODE and never left without reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (req_q && imem_ack) state_d = S_DECODE;
      S_DECODE: state_d = (opc == 6'b111111) ? S_HALTED : S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase
  end

  // PC advances only in WB; a taken beq adds the word offset, wrapping at PC_W bits.
  always_comb begin
    pc_d = pc_q;
    if (state_q == S_WB) begin
      pc_d = pc_q + PC_W'(4);
      if (aluop_q == OP_BEQ && a_q == b_q) pc_d = pc_q + PC_W'(4) + br_off_q;
    end
  end

  // Core state; request is registered so it drops the instant reset asserts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      req_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      alu_q    <= '0;
      zf_q     <= 1'b0;
      of_q     <= 1'b0;
      aluop_q  <= OP_NONE;
      wr_en_q  <= 1'b0;
      dst_q    <= '0;
      br_off_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= (state_d == S_FETCH);
      if (state_q == S_FETCH && req_q && imem_ack) ir_q <= imem_data;
      if (state_q == S_DECODE) begin
        a_q      <= rf_q[rs];
        b_q      <= dec_use_imm ? dec_imm : rf_q[rt];
        aluop_q  <= dec_op;
        wr_en_q  <= dec_wr;
        dst_q    <= dec_dst;
        br_off_q <= off64[PC_W-1:0];
      end
      if (state_q == S_EXEC && alu_upd) begin
        alu_q <= alu_d;
        zf_q  <= (alu_d == '0);
        of_q  <= of_d;
      end
    end
  end

  // Register file write port; register 0 is never written so it reads as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (state_q == S_WB && wr_en_q && dst_q != '0) begin
      rf_q[dst_q] <= alu_q;
    end
  end

  assign imem_addr = pc_q;
  assign imem_req  = req_q;
  assign ALU_F     = alu_q;
  assign ZF        = zf_q;
  assign OF        = of_q;
  assign halt      = (state_q == S_HALTED);
endmodule

// File: doc/rcpu_mc.md
RCPU_MC -- requirements
Module: rcpu_mc

Interface
REQ-001 Parameter DATA_W, default 32, datapath and register width (8..64).
REQ-002 Parameter PC_W, default 8, program counter width; byte address, word-aligned.
REQ-003 Parameter NREG_LOG2, default 5, register count 2^NREG_LOG2; register indices use the low NREG_LOG2 bits of each instruction field.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 imem_addr  output  PC_W  fetch address (= PC).
REQ-007 imem_req  output  1  fetch request.
REQ-008 imem_ack  input  1  instruction valid on imem_data this cycle.
REQ-009 imem_data  input  32  MIPS-format instruction word.
REQ-010 ALU_F  output  DATA_W  last ALU result (registered).
REQ-011 ZF  output  1  ALU_F == 0 (registered with ALU_F).
REQ-012 OF  output  1  signed overflow of last add/sub/addi (registered).
REQ-013 halt  output  1  core stopped by HALT instruction.

Function
REQ-014 The FSM SHALL have states FETCH, DECODE, EXEC, WB, HALTED; transitions: FETCH->DECODE on imem_ack, DECODE->EXEC, EXEC->WB, WB->FETCH, and DECODE->HALTED on opcode 6'b111111.
REQ-015 In FETCH, imem_req SHALL be 1 and imem_addr = PC; the instruction is latched into an internal IR on the cycle imem_ack=1. imem_req SHALL be 0 in all other states, and imem_ack SHALL be ignored outside FETCH.
REQ-016 Minimum latency SHALL be 4 cycles per instruction with zero-wait ack; each wait cycle in FETCH adds one cycle.
REQ-017 DECODE SHALL read rs and rt into operand registers A and B, and form imm: sign-extended for addi/beq and zero-extended for andi/ori, both to DATA_W.
REQ-018 R-type (opcode 0) func decode SHALL be: 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101011 sltu (result 1/0), 000100 sllv (B << A[log2(DATA_W)-1:0]); the destination is rd.
REQ-019 I-type decode SHALL be: 001000 addi, 001100 andi, 001101 ori, with the destination rt; 000100 beq, with no register write.
REQ-020 EXEC SHALL compute the result modulo 2^DATA_W and register ALU_F, ZF and OF; for beq it SHALL compute A-B (ZF updated, OF=0); OF SHALL be 0 for every operation other than add/sub/addi.
REQ-021 WB SHALL write the result to the destination register, with writes to register 0 discarded (register 0 always reads 0).
REQ-022 WB SHALL update PC: PC+4 by default, or PC+4+(imm<<2) when beq and A==B, truncated to PC_W bits (wrap-around, no trap).
REQ-023 An undefined opcode or func SHALL cause no register write, leave ALU_F/ZF/OF unchanged, and set PC+4.
REQ-024 HALTED SHALL be terminal until reset: halt=1, imem_req=0, PC frozen at the HALT address.
REQ-025 A register read in DECODE SHALL see every write completed in a prior WB; no bypass is needed because the FSM is single-issue.

Reset
REQ-026 While rst=0, the core SHALL asynchronously hold state=FETCH, PC=0, IR=0, all registers=0, ALU_F=0, ZF=0, OF=0, halt=0, imem_req=0.
REQ-027 Reset asserted mid-instruction (any state, including FETCH awaiting ack) SHALL abort the instruction with no register write and force imem_req to 0 immediately.
REQ-028 On the first posedge after rst deasserts, imem_req SHALL be 1 with imem_addr=0.

Verification
REQ-029 Program "addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2" with zero-wait ack -> after 12 cycles $3=2, ALU_F=2, ZF=0, OF=0, imem_addr=12.
REQ-030 $1=0x7FFFFFFF, $2=1, add $3,$1,$2 -> ALU_F=0x80000000, OF=1; then sub $4,$1,$1 -> ALU_F=0, ZF=1, OF=0.
REQ-031 beq $0,$0,-1 at PC=0xFC with PC_W=8 -> next imem_addr=0xFC (branch loop); beq $1,$0,+2 with $1!=0 -> PC+4.
REQ-032 imem_ack held low 3 cycles in FETCH -> imem_req stays 1, address stable, instruction completes in 7 cycles; addi $0,$0,9 -> $0 still reads 0.
REQ-033 rst pulsed low during EXEC of add $5,... -> $5 unchanged (0), imem_req=0 during reset, fetch restarts at address 0.
REQ-034 HALT word 0xFC000000 at address 8 -> halt=1 after DECODE of that word, imem_req=0 indefinitely; DATA_W=16 build repeats REQ-029 with a 16-bit result of 2.
